fetch_decode_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register.
- Holds the PC, presents it to instruction memory, and latches the returned instruction.
- Splits the latched instruction into decode fields.
- Drives Imm16 and the extend-control bit directly into the immediate sign/zero extender, and supplies register specifiers to the register file.
- Sits between instruction memory and the decode/extend stage.

---
 rtl/fetch_decode_stage.sv | 96 +++++++++
 tb/tb_fetch_decode_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Instruction fetch stage with IF/ID pipeline register and decode-field split.
// Holds the PC, latches returned instructions and pre-decodes the extender control bit.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          ZEXT_OPCODES_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Instr,
    input  logic        InstrValid,
    output logic [31:0] PC,
    output logic        IDValid,
    output logic [31:0] IDInstr,
    output logic [31:0] IDPCPlus4,
    output logic [5:0]  Opcode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [5:0]  Funct,
    output logic [15:0] Imm16,
    output logic        ExtCtrl
);

    logic [31:0] pc_q;
    logic        id_valid_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc_plus4_q;
    logic        ext_ctrl_q;
    logic [31:0] pc_plus4;
    logic        zext_dec;

    assign pc_plus4 = pc_q + 32'd4;

    // ANDI/ORI/XORI/LUI take a zero-extended immediate.
    always_comb begin
        zext_dec = 1'b0;
        if (ZEXT_OPCODES_EN) begin
            unique case (Instr[31:26])
                6'h0C, 6'h0D, 6'h0E, 6'h0F: zext_dec = 1'b1;
                default:                    zext_dec = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            ext_ctrl_q    <= 1'b0;
        end else if (BranchTaken) begin
            pc_q          <= {BranchTarget[31:2], 2'b00};
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            ext_ctrl_q    <= 1'b0;
        end else if (Flush) begin
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            ext_ctrl_q    <= 1'b0;
        end else if (Stall) begin
            pc_q          <= pc_q;
        end else if (InstrValid) begin
            pc_q          <= pc_plus4;
            id_valid_q    <= 1'b1;
            id_instr_q    <= Instr;
            id_pc_plus4_q <= pc_plus4;
            ext_ctrl_q    <= zext_dec;
        end else begin
            // Memory wait: insert an all-zero NOP bubble.
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            ext_ctrl_q    <= 1'b0;
        end
    end

    assign PC        = pc_q;
    assign IDValid   = id_valid_q;
    assign IDInstr   = id_instr_q;
    assign IDPCPlus4 = id_pc_plus4_q;
    assign Opcode    = id_instr_q[31:26];
    assign Rs        = id_instr_q[25:21];
    assign Rt        = id_instr_q[20:16];
    assign Rd        = id_instr_q[15:11];
    assign Funct     = id_instr_q[5:0];
    assign Imm16     = id_instr_q[15:0];
    assign ExtCtrl   = ext_ctrl_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch/IF-ID rules.
module tb_fetch_decode_stage;

    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        ext_ctrl;

    fetch_decode_stage #(
        .RESET_PC        (ResetPc),
        .ZEXT_OPCODES_EN (1'b1)
    ) dut (
        .CLK          (clk),
        .Reset_L      (rst_n),
        .Stall        (stall),
        .Flush        (flush),
        .BranchTaken  (br_taken),
        .BranchTarget (br_target),
        .Instr        (instr),
        .InstrValid   (instr_valid),
        .PC           (pc),
        .IDValid      (id_valid),
        .IDInstr      (id_instr),
        .IDPCPlus4    (id_pc4),
        .Opcode       (opcode),
        .Rs           (rs),
        .Rt           (rt),
        .Rd           (rd),
        .Funct        (funct),
        .Imm16        (imm16),
        .ExtCtrl      (ext_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    longint unsigned m_pc;
    bit              m_valid;
    longint unsigned m_instr;
    longint unsigned m_pc4;
    bit              m_ext;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = ResetPc; m_valid = 0; m_instr = 0; m_pc4 = 0; m_ext = 0;
    endtask

    // One clock edge of the architectural rules, applied to the inputs seen at that edge.
    task automatic model_edge();
        int unsigned op;
        if (br_taken) begin
            m_pc = (br_target / 4) * 4;
            m_valid = 0; m_instr = 0; m_pc4 = 0; m_ext = 0;
        end else if (flush) begin
            m_valid = 0; m_instr = 0; m_pc4 = 0; m_ext = 0;
        end else if (stall) begin
            // everything holds
        end else if (instr_valid) begin
            op      = instr / (1 << 26);
            m_pc    = (m_pc + 4) % 64'h1_0000_0000;
            m_pc4   = m_pc;
            m_instr = instr;
            m_valid = 1;
            m_ext   = (op >= 12 && op <= 15);
        end else begin
            m_valid = 0; m_instr = 0; m_pc4 = 0; m_ext = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},     pc,       32'(m_pc));
        check({tag, ".valid"},  {31'd0, id_valid}, {31'd0, m_valid});
        check({tag, ".instr"},  id_instr, 32'(m_instr));
        if (m_valid) check({tag, ".pc4"}, id_pc4, 32'(m_pc4));
        check({tag, ".opcode"}, {26'd0, opcode}, 32'((m_instr >> 26) % 64));
        check({tag, ".rs"},     {27'd0, rs},     32'((m_instr >> 21) % 32));
        check({tag, ".rt"},     {27'd0, rt},     32'((m_instr >> 16) % 32));
        check({tag, ".rd"},     {27'd0, rd},     32'((m_instr >> 11) % 32));
        check({tag, ".funct"},  {26'd0, funct},  32'(m_instr % 64));
        check({tag, ".imm16"},  {16'd0, imm16},  32'(m_instr % 65536));
        check({tag, ".ext"},    {31'd0, ext_ctrl}, {31'd0, m_ext});
    endtask

    // Apply inputs, take one edge, then compare everything away from the edge.
    task automatic cycle(input bit b, input bit f, input bit s, input bit v,
                         input logic [31:0] tgt, input logic [31:0] ins, input string tag);
        br_taken = b; flush = f; stall = s; instr_valid = v; br_target = tgt; instr = ins;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; stall = 0; flush = 0; br_taken = 0; br_target = 0;
        instr = 0; instr_valid = 0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Three sequential fetches with a 2-cycle stall at PC=8
        cycle(0, 0, 0, 1, 0, 32'h2008FFFF, "fetch0");
        check("fetch0.imm", {16'd0, imm16}, 32'h0000FFFF);
        cycle(0, 0, 0, 1, 0, 32'h3409FFFF, "fetch1");
        check("fetch1.ext", {31'd0, ext_ctrl}, 32'd1);
        cycle(0, 0, 1, 1, 0, 32'h8D2A0004, "stall0");
        cycle(0, 0, 1, 0, 0, 32'h8D2A0004, "stall1");
        check("stall.pc", pc, 32'h8);
        cycle(0, 0, 0, 1, 0, 32'h8D2A0004, "fetch2");
        check("fetch2.pc", pc, 32'hC);
        check("fetch2.pc4", id_pc4, 32'hC);

        // Branch overrides stall and flush
        cycle(1, 1, 1, 1, 32'h0000_0103, 32'h12345678, "branch");
        check("branch.pc", pc, 32'h100);
        cycle(0, 0, 0, 1, 0, 32'h00000020, "postbr");
        check("postbr.pc4", id_pc4, 32'h104);

        // Flush alone then memory wait at 0x10
        cycle(1, 0, 0, 0, 32'h10, 0, "br10");
        cycle(0, 0, 0, 1, 0, 32'h01095020, "f10");
        cycle(1, 0, 0, 0, 32'h10, 0, "br10b");
        cycle(0, 1, 0, 1, 0, 32'h01095020, "flush");
        check("flush.pc", pc, 32'h10);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 32'hDEADBEEF, "wait");

        // PC wrap
        cycle(1, 0, 0, 0, 32'hFFFF_FFFC, 0, "brwrap");
        cycle(0, 0, 0, 1, 0, 32'h3C01ABCD, "wrap");
        check("wrap.pc", pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if ($urandom_range(2) == 0) r[31:26] = 6'(12 + $urandom_range(3));
            cycle($urandom_range(15) == 0, $urandom_range(11) == 0, $urandom_range(5) == 0,
                  $urandom_range(3) != 0, $urandom, r, "rand");
        end

        // Asynchronous reset mid-cycle
        cycle(0, 0, 0, 1, 0, 32'h3C01ABCD, "prereset");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("areset.pc", pc, ResetPc);
        check("areset.valid", {31'd0, id_valid}, 32'd0);
        check("areset.instr", id_instr, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("inreset");
        for (int i = 0; i < 20; i++)
            cycle(0, 0, $urandom_range(3) == 0, 1, 0, $urandom, "after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
